hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 182 ++++++++++++++++++
 tb/tb_hazard_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller
//  Description : Hazard unit for a 5-stage pipeline. It forwards operands,
//                stalls on load-use and flushes on taken branches. It holds
//                the whole pipeline while data memory is busy, and enters a
//                sticky error state when memory does not answer in time.
//  Ports       : clk, rst (async, active-low)
//                Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM/RdW   register indices
//                RegWriteM/W, ResultSrcE, PCSrcE      pipeline control
//                MemAccessM, MemReadyM                data-memory handshake
//                ForwardAE/BE, Stall*, Flush*         hazard controls
//                State, MemErr                        FSM state, sticky error
//                StallCnt, FlushCnt                   performance counters
//  Options     : HAZARD_PERF_CNT_EN enables the StallCnt/FlushCnt counters;
//                when it is undefined, both outputs tie to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        ResultSrcE,
    input  logic        PCSrcE,
    input  logic        MemAccessM,
    input  logic        MemReadyM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [2:0]  State,
    output logic        MemErr,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'b000,
        ST_LDSTALL = 3'b001,
        ST_BRFLUSH = 3'b010,
        ST_MEMWAIT = 3'b011,
        ST_ERROR   = 3'b100
    } state_t;

    localparam logic [8:0] C_TIMEOUT = 9'(TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q;

    logic w_load_use;
    logic w_mem_busy;
    logic w_mem_stall;

    // Forwarding: the M-stage result is newer than W, so it wins.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
    end

    assign w_load_use = ResultSrcE && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
    assign w_mem_busy = MemAccessM && !MemReadyM;

    // Inside MEMWAIT only MemReadyM ends the wait. ERROR freezes the pipe for good.
    always_comb begin
        w_mem_stall = w_mem_busy;
        if (state_q == ST_MEMWAIT) w_mem_stall = !MemReadyM;
        if (state_q == ST_ERROR)   w_mem_stall = 1'b1;
    end

    // Stall/flush outputs. Memory stalls beat branches, and branches beat load-use.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (w_mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN, ST_LDSTALL, ST_BRFLUSH: begin
                if (w_mem_busy) begin
                    state_d    = ST_MEMWAIT;
                    wait_cnt_d = 8'd0;
                end else if (PCSrcE) begin
                    state_d = ST_BRFLUSH;
                end else if (w_load_use) begin
                    state_d = ST_LDSTALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEMWAIT: begin
                if (MemReadyM) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if ({1'b0, wait_cnt_q} + 9'd1 >= C_TIMEOUT) state_d = ST_ERROR;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= (state_d == ST_ERROR);
        end
    end

    assign State  = state_q;
    assign MemErr = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (StallF) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (FlushE) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = 32'd0;
    assign FlushCnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_controller
//  Description : Directed self-checking bench for hazard_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    localparam int C_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemAccessM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [2:0]  State;
    logic        MemErr;
    logic [31:0] StallCnt, FlushCnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_controller #(.TIMEOUT(C_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .State(State), .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
        MemAccessM = 0; MemReadyM = 1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use();
        ResultSrcE = 1; RdE = 5'd7; Rs2D = 5'd7;
    endtask

    initial begin
        clr();
        rst = 1'b0;
        #1;
        check("rst_state", {29'd0, State}, 32'd0);
        check("rst_memerr", {31'd0, MemErr}, 32'd0);
        check("rst_stallcnt", StallCnt, 32'd0);
        check("rst_flushcnt", FlushCnt, 32'd0);
        PCSrcE = 1; #1;
        check("rst_branch_flushD", {31'd0, FlushD}, 32'd1);
        clr();
        @(negedge clk) rst = 1'b1;
        tick();

        // Forwarding
        RdM = 5'd5; RegWriteM = 1; RdW = 5'd5; RegWriteW = 1; Rs1E = 5'd5; Rs2E = 5'd5; #1;
        check("fwdA_mem_prio", {30'd0, ForwardAE}, 32'd2);
        check("fwdB_mem_prio", {30'd0, ForwardBE}, 32'd2);
        RegWriteM = 0; #1;
        check("fwdA_wb", {30'd0, ForwardAE}, 32'd1);
        RdM = 5'd0; RegWriteM = 1; RdW = 5'd0; Rs1E = 5'd0; #1;
        check("fwdA_x0", {30'd0, ForwardAE}, 32'd0);
        RdM = 5'd3; RegWriteM = 0; RdW = 5'd3; RegWriteW = 1; Rs2E = 5'd3; #1;
        check("fwdB_wb", {30'd0, ForwardBE}, 32'd1);
        clr();

        // Load-use with x0 destination does not stall
        ResultSrcE = 1; RdE = 5'd0; Rs1D = 5'd0; #1;
        check("lu_x0_nostall", {31'd0, StallF}, 32'd0);
        clr();

        // Load-use stall
        load_use(); #1;
        check("lu_stall", {29'd0, StallF, StallD, FlushE}, 32'h7);
        check("lu_no_stallE", {31'd0, StallE}, 32'd0);
        tick(); clr(); #1;
        check("lu_state", {29'd0, State}, 32'd1);
        check("ldstall_no_out", {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 32'd0);
        tick();
        check("lu_back_run", {29'd0, State}, 32'd0);

        // Branch overrides load-use
        load_use(); PCSrcE = 1; #1;
        check("br_flush", {30'd0, FlushD, FlushE}, 32'h3);
        check("br_no_stall", {30'd0, StallF, StallD}, 32'd0);
        tick(); clr(); #1;
        check("br_state", {29'd0, State}, 32'd2);
        tick();

        // Memory wait: three busy cycles, then release with a held branch
        MemAccessM = 1; MemReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mw_stall%0d", i),
                  {27'd0, StallF, StallD, StallE, StallM, FlushW}, 32'h1F);
            check($sformatf("mw_noflushD%0d", i), {31'd0, FlushD}, 32'd0);
            PCSrcE = 1;
            tick();
            check($sformatf("mw_state%0d", i), {29'd0, State}, 32'd3);
        end
        MemReadyM = 1; #1;
        check("mw_release", {27'd0, StallF, StallD, StallE, StallM, FlushW}, 32'd0);
        check("mw_release_flushD", {31'd0, FlushD}, 32'd1);
        tick(); clr(); #1;
        check("mw_back_run", {29'd0, State}, 32'd0);

        // Timeout into ERROR
        MemAccessM = 1; MemReadyM = 0;
        tick();
        for (int i = 0; i < C_TIMEOUT - 1; i++) tick();
        check("to_still_wait", {29'd0, State}, 32'd3);
        tick();
        check("to_error", {29'd0, State}, 32'd4);
        check("to_memerr", {31'd0, MemErr}, 32'd1);
        clr(); RdM = 5'd9; RegWriteM = 1; Rs1E = 5'd9; #1;
        check("err_stall", {27'd0, StallF, StallD, StallE, StallM, FlushW}, 32'h1F);
        check("err_fwd", {30'd0, ForwardAE}, 32'd2);
        tick();
        check("err_sticky", {29'd0, State}, 32'd4);
        clr();
        rst = 1'b0; #1;
        check("err_rst_state", {29'd0, State}, 32'd0);
        check("err_rst_memerr", {31'd0, MemErr}, 32'd0);
        @(negedge clk) rst = 1'b1;
        tick();

        // Performance counters: 2 load-use stalls and 3 branches
        for (int i = 0; i < 2; i++) begin
            load_use(); tick(); clr(); tick();
        end
        for (int i = 0; i < 3; i++) begin
            PCSrcE = 1; tick(); clr(); tick();
        end
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stallcnt", StallCnt, 32'd2);
        check("perf_flushcnt", FlushCnt, 32'd5);
`else
        check("perf_stallcnt_off", StallCnt, 32'd0);
        check("perf_flushcnt_off", FlushCnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
